data_delay_calib: RTL and testbench

- Tap-calibration stage directly upstream of the data-bus delay-reset block; drives its 5-bit `delay_tap` input.
- On `start`, sweeps taps 0..31. At each tap it waits for the downstream reset pulse to complete, then checks deserialized `rx_data` against a fixed training pattern.
- Finds the longest contiguous passing window and applies its centre tap.
- Outside calibration, passes a register-block manual tap through.

---
 rtl/data_delay_calib.sv | 195 +++++++++++++++++++
 tb/tb_data_delay_calib.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_delay_calib.sv
// Sweeps the downstream delay tap 0..31, records which taps deliver the training
// pattern, then centres the tap in the longest passing window.
module data_delay_calib #(
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int                CHECK_CYCLES  = 64,
    parameter int                SETTLE_CYCLES = 8,
    parameter int                PULSE_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        manual_tap,
    input  logic              delay_data_reset,
    input  logic              delay_error,
    input  logic [DATA_W-1:0] rx_data,
    output logic [4:0]        delay_tap,
    output logic              busy,
    output logic              done,
    output logic              calib_fail,
    output logic [4:0]        eye_start,
    output logic [5:0]        eye_width,
    output logic [31:0]       pass_map
);

    localparam int TO_LAST     = (PULSE_TIMEOUT > 0) ? PULSE_TIMEOUT - 1 : 0;
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int CHECK_LAST  = (CHECK_CYCLES > 0) ? CHECK_CYCLES - 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SETTLE,
        S_CHECK,
        S_NEXT,
        S_PICK,
        S_APPLY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [4:0]  r_tap;
    logic [4:0]  r_tap_idx;
    logic        r_busy;
    logic        r_fail;
    logic        r_apply;
    logic        r_match;
    logic [31:0] r_pass_map;
    logic [5:0]  r_run_len;
    logic [4:0]  r_run_start;
    logic [5:0]  r_best_len;
    logic [4:0]  r_best_start;
    logic [4:0]  r_eye_start;
    logic [5:0]  r_eye_width;
    logic [4:0]  r_centre;

    logic        w_rx_ok;
    logic        w_counting;
    logic [5:0]  w_run_inc;
    logic [4:0]  w_run_start_new;
    logic [4:0]  w_centre;

    assign w_rx_ok         = (rx_data == TRAIN_PATTERN);
    assign w_counting      = (r_state == S_WAIT_HI) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign w_run_inc       = r_run_len + 6'd1;
    assign w_run_start_new = (r_run_len == 6'd0) ? r_tap_idx : r_run_start;
    // Even-width windows round toward the lower tap.
    assign w_centre        = r_best_start + 5'((r_best_len - 6'd1) >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_SET;
            S_SET:     w_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (delay_data_reset) w_next = S_WAIT_LO;
                else if (r_cnt == 8'(TO_LAST)) w_next = S_SETTLE;
            end
            S_WAIT_LO: if (!delay_data_reset) w_next = S_SETTLE;
            S_SETTLE: begin
                // A re-asserted reset is a downstream retry: wait it out and settle again.
                if (delay_data_reset) w_next = S_WAIT_LO;
                else if (r_cnt == 8'(SETTLE_LAST)) w_next = r_apply ? S_DONE : S_CHECK;
            end
            S_CHECK:   if (r_cnt == 8'(CHECK_LAST)) w_next = S_NEXT;
            S_NEXT:    w_next = (r_tap_idx == 5'd31) ? S_PICK : S_SET;
            S_PICK:    w_next = (r_best_len == 6'd0) ? S_DONE : S_APPLY;
            S_APPLY:   w_next = S_WAIT_HI;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_tap        <= '0;
            r_tap_idx    <= '0;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
            r_apply      <= 1'b0;
            r_match      <= 1'b0;
            r_pass_map   <= '0;
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_eye_start  <= '0;
            r_eye_width  <= '0;
            r_centre     <= '0;
        end else begin
            if (w_next != r_state) r_cnt <= '0;
            else if (w_counting)   r_cnt <= r_cnt + 8'd1;

            case (r_state)
                S_IDLE: begin
                    r_tap <= manual_tap;
                    if (start) begin
                        r_pass_map   <= '0;
                        r_fail       <= 1'b0;
                        r_run_len    <= '0;
                        r_run_start  <= '0;
                        r_best_len   <= '0;
                        r_best_start <= '0;
                        r_tap_idx    <= '0;
                        r_apply      <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_SET: r_tap <= r_tap_idx;
                S_SETTLE: begin
                    r_match <= 1'b1;
                    if (w_next == S_DONE && delay_error) r_fail <= 1'b1;
                end
                S_CHECK: begin
                    r_match <= r_match & w_rx_ok;
                    if (w_next == S_NEXT)
                        r_pass_map[r_tap_idx] <= r_match & w_rx_ok & ~delay_error;
                end
                S_NEXT: begin
                    if (r_pass_map[r_tap_idx]) begin
                        r_run_len   <= w_run_inc;
                        r_run_start <= w_run_start_new;
                        // Strict compare keeps the lower-tap window on ties.
                        if (w_run_inc > r_best_len) begin
                            r_best_len   <= w_run_inc;
                            r_best_start <= w_run_start_new;
                        end
                    end else begin
                        r_run_len <= '0;
                    end
                    if (r_tap_idx != 5'd31) r_tap_idx <= r_tap_idx + 5'd1;
                end
                S_PICK: begin
                    if (r_best_len == 6'd0) begin
                        r_fail <= 1'b1;
                        r_tap  <= manual_tap;
                    end else begin
                        r_eye_start <= r_best_start;
                        r_eye_width <= r_best_len;
                        r_centre    <= w_centre;
                        r_apply     <= 1'b1;
                    end
                end
                S_APPLY: r_tap <= r_centre;
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_apply <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign delay_tap  = r_tap;
    assign busy       = r_busy;
    assign done       = (r_state == S_DONE);
    assign calib_fail = r_fail;
    assign eye_start  = r_eye_start;
    assign eye_width  = r_eye_width;
    assign pass_map   = r_pass_map;

endmodule

// File: tb/tb_data_delay_calib.sv
// Scoreboard bench for data_delay_calib: a downstream delay-reset model drives the
// pulse/error/rx_data inputs and a reference computes the expected calibration result.
module tb_data_delay_calib;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  manual_tap;
    logic        delay_data_reset;
    logic        delay_error;
    logic [7:0]  rx_data;
    logic [4:0]  delay_tap;
    logic        busy;
    logic        done;
    logic        calib_fail;
    logic [4:0]  eye_start;
    logic [5:0]  eye_width;
    logic [31:0] pass_map;

    data_delay_calib dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .manual_tap       (manual_tap),
        .delay_data_reset (delay_data_reset),
        .delay_error      (delay_error),
        .rx_data          (rx_data),
        .delay_tap        (delay_tap),
        .busy             (busy),
        .done             (done),
        .calib_fail       (calib_fail),
        .eye_start        (eye_start),
        .eye_width        (eye_width),
        .pass_map         (pass_map)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [31:0] pmap;
        logic [4:0]  es;
        logic [5:0]  ew;
        logic        fail;
        logic [4:0]  tap;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    // Downstream model controls
    bit [31:0]   mask = '0;
    bit          err_mode = 1'b0;
    bit          retry_en = 1'b0;
    int          plen = 2;
    logic [4:0]  last_es = '0;
    logic [5:0]  last_ew = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Longest run of passing taps, lowest start wins ties; found by brute force over starts.
    function automatic exp_t ref_model(input bit [31:0] m, input logic [4:0] man, input bit err,
                                       input logic [4:0] pes, input logic [5:0] pew);
        exp_t r;
        int bl = 0;
        int bs = 0;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while (s + l < 32 && m[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        r.pmap = m;
        if (bl == 0) begin
            r.fail = 1'b1;
            r.tap  = man;
            r.es   = pes;
            r.ew   = pew;
        end else begin
            r.fail = err;
            r.es   = 5'(bs);
            r.ew   = 6'(bl);
            r.tap  = 5'(bs + (bl - 1) / 2);
        end
        return r;
    endfunction

    // Downstream delay-reset block: pulse 5 cycles after any tap change, optional retry pulse,
    // error raised once the tap leaves 31 (the apply step) when err_mode is set.
    initial begin
        logic [4:0] prev;
        int dly, hi;
        bit retried, apply_seen;
        logic [7:0] nz;
        prev = '0; dly = 0; hi = 0; retried = 0; apply_seen = 0;
        delay_data_reset = 1'b0;
        delay_error = 1'b0;
        rx_data = '0;
        forever begin
            @(negedge clk);
            if (!err_mode) apply_seen = 0;
            if (delay_tap !== prev) begin
                if (err_mode && prev == 5'd31) apply_seen = 1;
                prev = delay_tap;
                hi = 0;
                retried = 0;
                delay_data_reset = 1'b0;
                dly = 5;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    delay_data_reset = 1'b1;
                    hi = plen;
                end
            end else if (hi > 0) begin
                hi--;
                if (hi == 0) begin
                    delay_data_reset = 1'b0;
                    if (retry_en && !retried) begin
                        retried = 1;
                        dly = 3;
                    end
                end
            end
            delay_error = err_mode && apply_seen;
            nz = 8'($urandom_range(0, 255));
            if (nz == 8'hA5) nz = 8'h5A;
            rx_data = mask[delay_tap] ? 8'hA5 : nz;
        end
    end

    // Monitor: every done pulse is matched against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending calibration");
                end else begin
                    e = sb_q.pop_front();
                    check("pass_map",   pass_map,   e.pmap);
                    check("eye_start",  eye_start,  e.es);
                    check("eye_width",  eye_width,  e.ew);
                    check("calib_fail", calib_fail, e.fail);
                    check("final_tap",  delay_tap,  e.tap);
                    check("busy_at_done", busy, 1'b1);
                end
            end
        end
    end

    task automatic issue_start(input bit [31:0] m, input logic [4:0] man, input bit err);
        exp_t e;
        e = ref_model(m, man, err, last_es, last_ew);
        if (e.ew != 0) begin
            last_es = e.es;
            last_ew = e.ew;
        end
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_cal(input bit [31:0] m, input logic [4:0] man, input bit err, input bit poke);
        int target;
        mask = m;
        err_mode = err;
        manual_tap = man;
        repeat (30) @(negedge clk);
        target = done_cnt + 1;
        issue_start(m, man, err);
        for (int i = 0; i < 8000 && done_cnt < target; i++) begin
            @(negedge clk);
            start = poke && (i == 300);
        end
        start = 1'b0;
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 8000 cycles, expected done pulse");
            sb_q.delete();
        end
        err_mode = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("manual_passthrough", delay_tap, manual_tap);
    endtask

    task automatic check_reset_vals();
        check("rst_delay_tap",  delay_tap,  5'd0);
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_calib_fail", calib_fail, 1'b0);
        check("rst_eye_start",  eye_start,  5'd0);
        check("rst_eye_width",  eye_width,  6'd0);
        check("rst_pass_map",   pass_map,   32'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        manual_tap = 5'd5;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Single window 10..17
        run_cal(32'h0003_FC00, 5'd5, 1'b0, 1'b0);
        // Two equal windows: lower one wins
        run_cal(32'h0070_0038, 5'd9, 1'b0, 1'b1);
        // Nothing passes
        run_cal(32'h0000_0000, 5'd7, 1'b0, 1'b0);
        // Every tap passes but the apply step reports an error
        run_cal(32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0);
        // manual_tap = 0: no pulse for tap 0, WAIT_HI must time out
        run_cal($urandom() | 32'h1, 5'd0, 1'b0, 1'b0);

        // Reset in the middle of the tap-12 check
        mask = $urandom();
        manual_tap = 5'd20;
        repeat (30) @(negedge clk);
        issue_start(mask, manual_tap, 1'b0);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (delay_tap == 5'd12);
        end
        check("reached_tap12", found, 1'b1);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals();
        sb_q.delete();
        last_es = '0;
        last_ew = '0;
        @(negedge clk);
        reset = 1'b0;

        // Randomised sweeps after the mid-sweep reset
        for (int k = 0; k < 3; k++) begin
            retry_en = ($urandom_range(0, 1) == 1);
            plen = $urandom_range(1, 3);
            run_cal($urandom() & $urandom(), 5'($urandom_range(0, 31)), 1'b0, (k == 1));
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
